restoring_unsigned_divider_cla: RTL and testbench
=================================================

Name: restoring_unsigned_divider_cla

Overview:
Sequential unsigned restoring divider. It is the inverse datapath to the team's 4x4 Wallace/CLA unsigned multiplier: it takes a 2N-bit dividend (product width) and an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder. One quotient bit is resolved per clock. The trial subtraction uses a carry-lookahead subtractor, matching the multiplier's final-stage adder style. It sits beside the multiplier in the arithmetic library and round-trips its outputs.

Parameters:
N, 4, divisor/remainder width; dividend and quotient are 2N bits; N >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  2N  unsigned dividend, captured when start is accepted
divisor  input  N  unsigned divisor, captured when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid
quotient  output  2N  registered result
remainder  output  N  registered result
div_by_zero  output  1  registered; high if the captured divisor == 0

Behaviour:
Interface:
- Single clock, clk.
- Reset is synchronous and active-high on rst.

Reset (rst=1 at an edge, any state, including mid-operation):
- state=IDLE.
- busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Iteration counter = 0. Any in-flight operation is abandoned.

States:
- IDLE: if start=1 at an edge, capture the operands.
  - Divisor==0: go directly to DONE with div_by_zero=1, quotient=all ones, remainder=0.
  - Otherwise: partial remainder R (N+1 bits)=0, working register Q=dividend, counter=2N-1, go to RUN, div_by_zero=0.
  - start=0: stay in IDLE.
- RUN: each edge performs one restoring step.
  - T = {R[N-1:0], Q[2N-1]}, which is N+1 bits.
  - D = T - {0,divisor}, computed by the CLA subtractor.
  - No borrow: R=D, Q={Q[2N-2:0],1}.
  - Borrow: R=T, Q={Q[2N-2:0],0}.
  - Counter decrements. At the step where counter==0, go to DONE and load quotient=next Q and remainder=next R[N-1:0].
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE. start is ignored in DONE.

Latency:
- Start accepted at edge 0; RUN steps occur at edges 1..2N; done is high in the cycle after edge 2N.
- Total 2N+1 cycles from start to the done cycle.
- Divide-by-zero: done is high in the cycle after edge 0.

Output holding and handshake:
- quotient, remainder and div_by_zero change only on entry to DONE or on reset.
- They hold their values through IDLE until the next completion.
- start while busy=1 has no effect; the in-flight operands are unaffected.
- Back-to-back operation: start asserted in the first IDLE cycle after DONE is accepted. Minimum spacing between start acceptances is 2N+2 cycles.

Width rules:
- All arithmetic is unsigned.
- R never exceeds divisor-1 after a step, so N+1 bits suffice.
- The quotient is the full 2N bits; there is no overflow condition.
- Invariant at done (divisor != 0): quotient*divisor + remainder == dividend and remainder < divisor.

Decomposition:
- Shared arithmetic package: state encoding enum (IDLE, RUN, DONE) and the DIV_BY_ZERO_QUOTIENT constant (all ones).
- One sub-module, cla_subtractor: combinational, width N+1.
  - Inputs: a, b. Outputs: diff, borrow_out.
  - Implements a + ~b + 1 using explicit per-bit generate/propagate and lookahead carries, in the same G/P/C form as the multiplier's final adder.
  - borrow_out = ~carry_out.
- The top level holds the FSM, counter, R/Q registers and output registers.

Test Plan:
- N=4, dividend=200, divisor=13, start one cycle -> busy for cycles 0..8; done high exactly one cycle, 9 cycles after start; quotient=15, remainder=5, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=0, divisor=7 -> quotient=0, remainder=0. Outputs hold between operations.
- dividend=100, divisor=0 -> done in the cycle after start, div_by_zero=1, quotient=8'hFF, remainder=0. A following 100/10 clears div_by_zero and gives quotient=10, remainder=0.
- Start 200/13; at cycle 3 pulse start with 9/3 -> the second request is ignored, result 15 r 5. Start held high continuously -> new operations accepted every 10 cycles.
- Start 225/15; assert rst at cycle 4 -> next cycle busy=0, done=0, outputs=0. A new start of 225/15 completes normally: quotient=15, remainder=0.
- Exhaustive round-trip: for all a in 0..15 and b in 1..15, divide the multiplier product a*b by b -> quotient=a, remainder=0. Also check all 256x16 operand pairs against the invariant.

Source files
------------

// File: rtl/restoring_unsigned_divider_cla_pkg.sv
// Shared definitions for the restoring unsigned divider: FSM state encoding
// and the quotient reported when the divisor is zero.
package restoring_unsigned_divider_cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Wide enough for any practical quotient; the top slices off 2N bits.
   localparam int unsigned MAX_QUOTIENT_W = 64;
   localparam logic [MAX_QUOTIENT_W-1:0] DIV_BY_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/restoring_unsigned_divider_cla_if.sv
// Request/result bundle of the restoring divider; master issues operands,
// slave (the divider) returns status and registered results.
interface restoring_unsigned_divider_cla_if #(
   parameter int unsigned N = 4
);
   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [2*N-1:0] quotient;
   logic [N-1:0]   remainder;
   logic           div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/restoring_unsigned_divider_cla_cla_subtractor.sv
// Combinational a - b as a + ~b + 1 with flattened generate/propagate
// lookahead carries; borrow_out_o is the inverted carry out.
module cla_subtractor #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_out_o
);

   logic [W-1:0] b_n;
   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   c;
   logic         term;

   assign b_n = ~b_i;
   assign g   = a_i & b_n;
   assign p   = a_i ^ b_n;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c0, with c0 = 1 for the +1
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = 1'b1;
      for (int unsigned i = 0; i < W; i++) begin
         c[i+1] = g[i];
         for (int unsigned j = 0; j < i; j++) begin
            term = g[j];
            for (int unsigned k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            c[i+1] = c[i+1] | term;
         end
         term = 1'b1;
         for (int unsigned k = 0; k <= i; k++) begin
            term = term & p[k];
         end
         c[i+1] = c[i+1] | term;
      end
   end

   assign diff_o       = p ^ c[W-1:0];
   assign borrow_out_o = ~c[W];

endmodule

// File: rtl/restoring_unsigned_divider_cla.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per clock, trial subtraction through a CLA subtractor.
module restoring_unsigned_divider_cla
   import restoring_unsigned_divider_cla_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   restoring_unsigned_divider_cla_if.slave   bus
);

   localparam int unsigned QW = 2 * N;
   localparam int unsigned CW = $clog2(QW);

   div_state_e    state_q;
   logic [N:0]    r_q;
   logic [QW-1:0] q_q;
   logic [N-1:0]  divisor_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          done_q;
   logic [QW-1:0] quotient_q;
   logic [N-1:0]  remainder_q;
   logic          dbz_q;

   logic [N:0]    t_d;
   logic [N:0]    diff_d;
   logic          borrow_d;
   logic [N:0]    r_d;
   logic [QW-1:0] q_d;

   // R stays below the divisor after every step, so its MSB never feeds T.
   logic          unused_r_msb;
   assign unused_r_msb = r_q[N];

   assign t_d = {r_q[N-1:0], q_q[QW-1]};

   cla_subtractor #(
      .W (N + 1)
   ) u_sub (
      .a_i          (t_d),
      .b_i          ({1'b0, divisor_q}),
      .diff_o       (diff_d),
      .borrow_out_o (borrow_d)
   );

   always_comb begin
      r_d = borrow_d ? t_d : diff_d;
      q_d = {q_q[QW-2:0], ~borrow_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         divisor_q   <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  divisor_q <= bus.divisor;
                  busy_q    <= 1'b1;
                  if (bus.divisor == '0) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     dbz_q       <= 1'b1;
                     quotient_q  <= DIV_BY_ZERO_QUOTIENT[QW-1:0];
                     remainder_q <= '0;
                  end else begin
                     state_q <= RUN;
                     r_q     <= '0;
                     q_q     <= bus.dividend;
                     cnt_q   <= CW'(QW - 1);
                  end
               end
            end
            RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CW'(1);
               // div_by_zero is cleared on DONE entry so results only move at completion
               if (cnt_q == '0) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  quotient_q  <= q_d;
                  remainder_q <= r_d[N-1:0];
                  dbz_q       <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_unsigned_divider_cla.sv
// Scoreboard bench for restoring_unsigned_divider_cla (N=4): stimulus pushes
// expected results, a negedge monitor pops and compares on every done pulse.
module tb_restoring_unsigned_divider_cla;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dbz;
   } exp_t;

   logic clk;
   logic rst;
   logic rst_d;
   logic mon_en;
   int   total;
   int   bad;
   exp_t sb[$];
   exp_t e;
   logic [7:0] hold_q;
   logic [3:0] hold_r;
   logic       hold_dbz;

   restoring_unsigned_divider_cla_if #(.N(4)) bus ();

   restoring_unsigned_divider_cla #(.N(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rst_d <= rst;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops on done, otherwise confirms results hold their last values.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_d === 1'b1) begin
            hold_q   = '0;
            hold_r   = '0;
            hold_dbz = 1'b0;
         end
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("quotient", 32'(bus.quotient), 32'(e.q));
               check("remainder", 32'(bus.remainder), 32'(e.r));
               check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
               if (e.b != 0)
                  check("invariant",
                        32'(((int'(bus.quotient) * int'(e.b) + int'(bus.remainder)) == int'(e.a))
                            && (bus.remainder < e.b)), 32'd1);
               hold_q   = e.q;
               hold_r   = e.r;
               hold_dbz = e.dbz;
            end
         end else begin
            check("hold_quotient", 32'(bus.quotient), 32'(hold_q));
            check("hold_remainder", 32'(bus.remainder), 32'(hold_r));
            check("hold_dbz", 32'(bus.div_by_zero), 32'(hold_dbz));
         end
      end
   end

   // Entered #1 after an edge with the DUT idle or in the cycle showing done.
   task automatic wait_done(input int start_cyc, input int exp_cyc);
      int cyc;
      cyc = start_cyc;
      while (bus.done !== 1'b1 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("done_latency", 32'(cyc), 32'(exp_cyc));
      @(posedge clk); #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("idle_after_done", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input logic edbz);
      sb.push_back('{a: a, b: b, q: eq, r: er, dbz: edbz});
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      wait_done(0, (b == 0) ? 0 : 8);
   endtask

   initial begin
      int dn[3];
      int n;
      int cyc;
      total        = 0;
      bad          = 0;
      mon_en       = 1'b0;
      hold_q       = '0;
      hold_r       = '0;
      hold_dbz     = 1'b0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      do_op(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
      do_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
      do_op(8'd0, 4'd7, 8'd0, 4'd0, 1'b0);
      do_op(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
      do_op(8'd100, 4'd10, 8'd10, 4'd0, 1'b0);
      do_op(8'd77, 4'd15, 8'd5, 4'd2, 1'b0);

      // Start pulse during RUN must not disturb the operation in flight.
      sb.push_back('{a: 8'd200, b: 4'd13, q: 8'd15, r: 4'd5, dbz: 1'b0});
      bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd13;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      wait_done(3, 8);

      // Start held high: acceptances every 10 cycles.
      repeat (3) sb.push_back('{a: 8'd100, b: 4'd7, q: 8'd14, r: 4'd2, dbz: 1'b0});
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd7;
      @(posedge clk); #1;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 100) begin
         if (bus.done === 1'b1) begin
            dn[n] = cyc;
            n++;
            if (n == 3) bus.start = 1'b0;
         end
         if (n < 3) begin @(posedge clk); #1; cyc++; end
      end
      check("held_start_count", 32'(n), 32'd3);
      check("held_first_done", 32'(dn[0]), 32'd8);
      check("held_spacing_1", 32'(dn[1] - dn[0]), 32'd10);
      check("held_spacing_2", 32'(dn[2] - dn[1]), 32'd10);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("held_idle", 32'(bus.busy), 32'd0);

      // Reset mid-operation abandons the work and clears results.
      bus.start = 1'b1; bus.dividend = 8'd225; bus.divisor = 4'd15;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_quotient", 32'(bus.quotient), 32'd0);
      check("midrst_remainder", 32'(bus.remainder), 32'd0);
      check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
      do_op(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);

      // Round trip of every 4x4 product back through its divisor.
      for (int a = 0; a < 16; a++)
         for (int b = 1; b < 16; b++)
            do_op(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);

      // Full operand sweep.
      for (int d = 0; d < 256; d++)
         for (int b = 0; b < 16; b++)
            do_op(8'(d), 4'(b), (b == 0) ? 8'hFF : 8'(d / b),
                  (b == 0) ? 4'd0 : 4'(d % b), (b == 0));

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
